// File: rtl/gr8_dram_sched.sv
// GR8RAM DRAM slot scheduler: one slot per 6502 cycle, sequencing RAS/CAS/
// address-mux for a CPU window access, a pseudo-DMA transfer, or a
// CAS-before-RAS refresh. Refresh uses the early phases (S1-S3) and data
// accesses use the late phases (S4-S7).
module gr8_dram_sched #(
  parameter int unsigned REF_INTERVAL    = 13,
  parameter int unsigned REF_MAX_PENDING = 4
) (
  input  logic       C7M,
  input  logic       nRES,
  input  logic [2:0] S,
  input  logic       cpu_sel,
  input  logic       cpu_wr,
  input  logic       cpu_bank,
  input  logic       pdma_req,
  input  logic       pdma_wr,
  input  logic       pdma_bank,
  output logic       RAS,
  output logic       CAS0,
  output logic       CAS1,
  output logic       CASel,
  output logic       gnt_cpu,
  output logic       gnt_pdma,
  output logic       acc_done,
  output logic [2:0] ref_pending,
  output logic       ref_overrun
);

  localparam int unsigned CW       = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REF_INTERVAL - 1);
  localparam logic [2:0]    PEND_MAX = 3'(REF_MAX_PENDING);

  typedef enum logic [2:0] {
    IDLE,
    REF_C,
    REF_RC,
    ACC_W,
    ACC_R,
    ACC_M,
    ACC_C
  } state_e;

  state_e        state_q, state_d;
  logic          bank_q, bank_d;
  logic          own_cpu_q, own_cpu_d;
  logic [1:0]    tmo_q, tmo_d;
  logic [CW-1:0] ivl_q, ivl_d;
  logic [2:0]    pend_q, pend_d;
  logic          ovr_q, ovr_d;
  logic          ras_q, ras_d;
  logic          cas0_q, cas0_d;
  logic          cas1_q, cas1_d;
  logic          casel_q, casel_d;
  logic          gcpu_q, gcpu_d;
  logic          gpdma_q, gpdma_d;
  logic          done_q, done_d;

  logic          s_one;
  logic          ref_done;
  logic          wrap;
  logic          inc;
  logic          in_acc;

  assign s_one = (S == 3'd1);

  // Slot sequencer: next state, latched owner/bank, ACC_C stall timeout
  always_comb begin
    state_d   = state_q;
    bank_d    = bank_q;
    own_cpu_d = own_cpu_q;
    tmo_d     = '0;
    done_d    = 1'b0;
    ref_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (s_one && (pend_q != '0)) begin
          state_d = REF_C;
        end else if (S == 3'd4) begin
          if (cpu_sel) begin
            state_d   = cpu_wr ? ACC_W : ACC_R;
            bank_d    = cpu_bank;
            own_cpu_d = 1'b1;
          end else if (pdma_req && (pend_q < PEND_MAX)) begin
            state_d   = pdma_wr ? ACC_W : ACC_R;
            bank_d    = pdma_bank;
            own_cpu_d = 1'b0;
          end
        end
      end
      REF_C:  state_d = REF_RC;
      REF_RC: begin
        state_d  = IDLE;
        ref_done = 1'b1;
      end
      ACC_W:  state_d = s_one ? IDLE : ACC_R;
      ACC_R:  state_d = s_one ? IDLE : ACC_M;
      ACC_M:  state_d = s_one ? IDLE : ACC_C;
      ACC_C: begin
        // tmo_q counts stalled edges already spent here; the 4th one releases
        if (s_one || (tmo_q == 2'd3)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          tmo_d = tmo_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobe decode from the next state so every output is a plain register
  always_comb begin
    in_acc  = (state_d == ACC_W) || (state_d == ACC_R) ||
              (state_d == ACC_M) || (state_d == ACC_C);
    ras_d   = (state_d == REF_RC) || (state_d == ACC_R) ||
              (state_d == ACC_M)  || (state_d == ACC_C);
    casel_d = (state_d == ACC_M) || (state_d == ACC_C);
    cas0_d  = (state_d == REF_C) || (state_d == REF_RC) ||
              ((state_d == ACC_C) && !bank_d);
    cas1_d  = (state_d == REF_C) || (state_d == REF_RC) ||
              ((state_d == ACC_C) && bank_d);
    gcpu_d  = in_acc && own_cpu_d;
    gpdma_d = in_acc && !own_cpu_d;
  end

  // Refresh interval counter and owed-refresh bookkeeping
  always_comb begin
    wrap   = (S == 3'd3) && (ivl_q == CNT_LAST);
    ivl_d  = ivl_q;
    if (S == 3'd3) begin
      ivl_d = wrap ? '0 : ivl_q + CW'(1);
    end
    // a wrap coinciding with a completed refresh is not lost at saturation
    inc    = wrap && ((pend_q < PEND_MAX) || ref_done);
    pend_d = pend_q;
    if (inc && !ref_done) begin
      pend_d = pend_q + 3'd1;
    end else if (!inc && ref_done) begin
      pend_d = pend_q - 3'd1;
    end
    ovr_d  = ovr_q | (wrap && (pend_q == PEND_MAX) && !ref_done);
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge C7M or negedge nRES) begin
    if (!nRES) begin
      state_q   <= IDLE;
      bank_q    <= 1'b0;
      own_cpu_q <= 1'b0;
      tmo_q     <= '0;
      ivl_q     <= '0;
      pend_q    <= '0;
      ovr_q     <= 1'b0;
      ras_q     <= 1'b0;
      cas0_q    <= 1'b0;
      cas1_q    <= 1'b0;
      casel_q   <= 1'b0;
      gcpu_q    <= 1'b0;
      gpdma_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bank_q    <= bank_d;
      own_cpu_q <= own_cpu_d;
      tmo_q     <= tmo_d;
      ivl_q     <= ivl_d;
      pend_q    <= pend_d;
      ovr_q     <= ovr_d;
      ras_q     <= ras_d;
      cas0_q    <= cas0_d;
      cas1_q    <= cas1_d;
      casel_q   <= casel_d;
      gcpu_q    <= gcpu_d;
      gpdma_q   <= gpdma_d;
      done_q    <= done_d;
    end
  end

  assign RAS         = ras_q;
  assign CAS0        = cas0_q;
  assign CAS1        = cas1_q;
  assign CASel       = casel_q;
  assign gnt_cpu     = gcpu_q;
  assign gnt_pdma    = gpdma_q;
  assign acc_done    = done_q;
  assign ref_pending = pend_q;
  assign ref_overrun = ovr_q;

endmodule
